// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file: FSM state encoding
// and default geometry. Optional build macro REGFILE_BYPASS_EN is consumed
// by regfile_mp (write-to-read forwarding).
package regfile_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_NUM_REGS   = 32;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } rf_state_e;

endpackage

// File: rtl/regfile_clear_ctrl.sv
// Clear sequencer for regfile_mp. Walks clr_cnt over every entry (one per
// rising edge) after reset or a clear request, then parks in IDLE where the
// file accepts writes. Reset is synchronous, active high.
module regfile_clear_ctrl
    import regfile_pkg::*;
#(
    parameter  int NUM_REGS   = DEFAULT_NUM_REGS,
    localparam int ADDR_WIDTH = $clog2(NUM_REGS)
) (
    input  logic                  clk,
    input  logic                  i_reset,
    input  logic                  i_clear,
    output logic                  o_ready,
    output logic                  clr_we,
    output logic [ADDR_WIDTH-1:0] clr_addr
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_REGS - 1);

    rf_state_e             state_r;
    rf_state_e             state_nxt_s;
    logic [ADDR_WIDTH-1:0] clr_cnt_r;
    logic [ADDR_WIDTH-1:0] clr_cnt_nxt_s;
    logic                  ready_s;
    logic                  clr_we_s;

    // State and clear-counter register; reset restarts the clear from entry 0
    always_ff @(posedge clk) begin
        if (i_reset) begin
            state_r   <= ST_CLEAR;
            clr_cnt_r <= {ADDR_WIDTH{1'b0}};
        end else begin
            state_r   <= state_nxt_s;
            clr_cnt_r <= clr_cnt_nxt_s;
        end
    end

    // Next-state logic: leave CLEAR on the edge that zeroes the last entry
    always_comb begin
        state_nxt_s   = state_r;
        clr_cnt_nxt_s = clr_cnt_r;
        case (state_r)
            ST_CLEAR: begin
                clr_cnt_nxt_s = clr_cnt_r + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
                if (clr_cnt_r == LAST_ADDR) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_CLEAR;
                end
            end
            ST_IDLE: begin
                if (i_clear) begin
                    state_nxt_s   = ST_CLEAR;
                    clr_cnt_nxt_s = {ADDR_WIDTH{1'b0}};
                end else begin
                    state_nxt_s   = ST_IDLE;
                    clr_cnt_nxt_s = clr_cnt_r;
                end
            end
            default: begin
                state_nxt_s   = ST_CLEAR;
                clr_cnt_nxt_s = {ADDR_WIDTH{1'b0}};
            end
        endcase
    end

    // Output decode straight from the state flop so o_ready is glitch-free
    always_comb begin
        ready_s  = 1'b0;
        clr_we_s = 1'b0;
        case (state_r)
            ST_CLEAR: clr_we_s = 1'b1;
            ST_IDLE:  ready_s  = 1'b1;
            default: begin
                ready_s  = 1'b0;
                clr_we_s = 1'b0;
            end
        endcase
    end

    assign o_ready  = ready_s;
    assign clr_we   = clr_we_s;
    assign clr_addr = clr_cnt_r;

endmodule

// File: rtl/regfile_mp.sv
// Two-read/one-write register file with a debug read port. Writes land on
// the rising edge; all read ports are registered on the falling edge and read
// as zero while the file is clearing. Entry 0 is hard-wired to zero.
// Build macro REGFILE_BYPASS_EN: forward same-cycle write data to rs/rt.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter  int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter  int NUM_REGS   = DEFAULT_NUM_REGS,
    localparam int ADDR_WIDTH = $clog2(NUM_REGS)
) (
    input  logic                  clk,
    input  logic                  i_reset,
    input  logic                  i_clear,
    input  logic                  i_wenable,
    input  logic [ADDR_WIDTH-1:0] i_addres_data,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic [ADDR_WIDTH-1:0] i_addres_rs,
    input  logic [ADDR_WIDTH-1:0] i_addres_rt,
    output logic [DATA_WIDTH-1:0] o_data_rs,
    output logic [DATA_WIDTH-1:0] o_data_rt,
    input  logic [ADDR_WIDTH-1:0] i_dbg_addr,
    output logic [DATA_WIDTH-1:0] o_dbg_data,
    output logic                  o_ready
);

    localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = {ADDR_WIDTH{1'b0}};
    localparam logic [DATA_WIDTH-1:0] ZERO_DATA = {DATA_WIDTH{1'b0}};

    logic [DATA_WIDTH-1:0] mem_r [NUM_REGS];
    logic                  ready_s;
    logic                  clr_we_s;
    logic [ADDR_WIDTH-1:0] clr_addr_s;
    logic                  wr_s;
    logic [DATA_WIDTH-1:0] rs_val_s;
    logic [DATA_WIDTH-1:0] rt_val_s;
    logic [DATA_WIDTH-1:0] dbg_val_s;

    regfile_clear_ctrl #(
        .NUM_REGS (NUM_REGS)
    ) u_clear_ctrl (
        .clk      (clk),
        .i_reset  (i_reset),
        .i_clear  (i_clear),
        .o_ready  (ready_s),
        .clr_we   (clr_we_s),
        .clr_addr (clr_addr_s)
    );

    // A user write commits only when idle, non-zero target, and no clear/reset wins
    assign wr_s = ready_s & i_wenable & (i_addres_data != ZERO_ADDR) & ~i_clear & ~i_reset;

`ifdef REGFILE_BYPASS_EN
    logic byp_en_s;
    assign byp_en_s = ready_s & i_wenable & (i_addres_data != ZERO_ADDR);
`endif

    // Storage write port; the clear sequence owns the array while active
    always_ff @(posedge clk) begin
        if (clr_we_s) begin
            mem_r[clr_addr_s] <= ZERO_DATA;
        end else if (wr_s) begin
            mem_r[i_addres_data] <= i_data;
        end else begin
            mem_r[i_addres_data] <= mem_r[i_addres_data];
        end
    end

    // Read-port muxes: entry 0 reads zero, optional forwarding on rs/rt only
    always_comb begin
        rs_val_s  = ZERO_DATA;
        rt_val_s  = ZERO_DATA;
        dbg_val_s = ZERO_DATA;

        if (i_addres_rs == ZERO_ADDR) begin
            rs_val_s = ZERO_DATA;
`ifdef REGFILE_BYPASS_EN
        end else if (byp_en_s && (i_addres_data == i_addres_rs)) begin
            rs_val_s = i_data;
`endif
        end else begin
            rs_val_s = mem_r[i_addres_rs];
        end

        if (i_addres_rt == ZERO_ADDR) begin
            rt_val_s = ZERO_DATA;
`ifdef REGFILE_BYPASS_EN
        end else if (byp_en_s && (i_addres_data == i_addres_rt)) begin
            rt_val_s = i_data;
`endif
        end else begin
            rt_val_s = mem_r[i_addres_rt];
        end

        if (i_dbg_addr == ZERO_ADDR) begin
            dbg_val_s = ZERO_DATA;
        end else begin
            dbg_val_s = mem_r[i_dbg_addr];
        end
    end

    // Falling-edge output registers, held at zero while reset or clearing
    always_ff @(negedge clk) begin
        if (i_reset || !ready_s) begin
            o_data_rs  <= ZERO_DATA;
            o_data_rt  <= ZERO_DATA;
            o_dbg_data <= ZERO_DATA;
        end else begin
            o_data_rs  <= rs_val_s;
            o_data_rt  <= rt_val_s;
            o_dbg_data <= dbg_val_s;
        end
    end

    assign o_ready = ready_s;

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: stimulus pushes the expected read-port
// values for the coming falling edge; a monitor pops and compares them.
// Covers the default 32x32 file and a 16-bit x 8-entry instance.
module tb_regfile_mp;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct {
        string       name;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] dbg;
        logic        rdy;
    } exp_t;

    exp_t q_big[$];
    exp_t q_small[$];
    int   total = 0;
    int   bad   = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Default-size instance
    logic        b_reset, b_clear, b_wen;
    logic [4:0]  b_wa, b_ra, b_rb, b_dg;
    logic [31:0] b_wd;
    logic [31:0] b_rs_o, b_rt_o, b_dbg_o;
    logic        b_rdy_o;

    regfile_mp u_big (
        .clk           (clk),
        .i_reset       (b_reset),
        .i_clear       (b_clear),
        .i_wenable     (b_wen),
        .i_addres_data (b_wa),
        .i_data        (b_wd),
        .i_addres_rs   (b_ra),
        .i_addres_rt   (b_rb),
        .o_data_rs     (b_rs_o),
        .o_data_rt     (b_rt_o),
        .i_dbg_addr    (b_dg),
        .o_dbg_data    (b_dbg_o),
        .o_ready       (b_rdy_o)
    );

    // Small instance: 16-bit data, 8 entries
    logic        s_reset, s_clear, s_wen;
    logic [2:0]  s_wa, s_ra, s_rb, s_dg;
    logic [15:0] s_wd;
    logic [15:0] s_rs_o, s_rt_o, s_dbg_o;
    logic        s_rdy_o;

    regfile_mp #(.DATA_WIDTH(16), .NUM_REGS(8)) u_small (
        .clk           (clk),
        .i_reset       (s_reset),
        .i_clear       (s_clear),
        .i_wenable     (s_wen),
        .i_addres_data (s_wa),
        .i_data        (s_wd),
        .i_addres_rs   (s_ra),
        .i_addres_rt   (s_rb),
        .o_data_rs     (s_rs_o),
        .o_data_rt     (s_rt_o),
        .i_dbg_addr    (s_dg),
        .o_dbg_data    (s_dbg_o),
        .o_ready       (s_rdy_o)
    );

    task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s.%s: got %h want %h (t=%0t)", nm, fld, act, exp, $time);
        end
    endtask

    // Monitor: outputs settle on the falling edge, sample 1 time unit later
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (q_big.size() != 0) begin
                e = q_big.pop_front();
                chk(e.name, "rs",  b_rs_o,  e.rs);
                chk(e.name, "rt",  b_rt_o,  e.rt);
                chk(e.name, "dbg", b_dbg_o, e.dbg);
                chk(e.name, "rdy", {31'd0, b_rdy_o}, {31'd0, e.rdy});
            end
            if (q_small.size() != 0) begin
                e = q_small.pop_front();
                chk(e.name, "rs",  {16'h0000, s_rs_o},  e.rs);
                chk(e.name, "rt",  {16'h0000, s_rt_o},  e.rt);
                chk(e.name, "dbg", {16'h0000, s_dbg_o}, e.dbg);
                chk(e.name, "rdy", {31'd0, s_rdy_o}, {31'd0, e.rdy});
            end
        end
    end

    // One cycle on the big instance: drive, queue expectation, advance
    task automatic bs(input string nm, input logic rst, input logic clr, input logic we,
                      input logic [4:0] wa, input logic [31:0] wd,
                      input logic [4:0] ra, input logic [4:0] rb, input logic [4:0] dg,
                      input logic [31:0] ers, input logic [31:0] ert, input logic [31:0] edg,
                      input logic erdy);
        exp_t e;
        b_reset = rst; b_clear = clr; b_wen = we; b_wa = wa; b_wd = wd;
        b_ra = ra; b_rb = rb; b_dg = dg;
        e.name = nm; e.rs = ers; e.rt = ert; e.dbg = edg; e.rdy = erdy;
        q_big.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // One cycle on the small instance
    task automatic ss(input string nm, input logic rst, input logic clr, input logic we,
                      input logic [2:0] wa, input logic [15:0] wd,
                      input logic [2:0] ra, input logic [2:0] rb, input logic [2:0] dg,
                      input logic [15:0] ers, input logic [15:0] ert, input logic [15:0] edg,
                      input logic erdy);
        exp_t e;
        s_reset = rst; s_clear = clr; s_wen = we; s_wa = wa; s_wd = wd;
        s_ra = ra; s_rb = rb; s_dg = dg;
        e.name = nm; e.rs = {16'h0000, ers}; e.rt = {16'h0000, ert};
        e.dbg = {16'h0000, edg}; e.rdy = erdy;
        q_small.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        b_reset = 1'b1; b_clear = 1'b0; b_wen = 1'b0; b_wa = 5'd0; b_wd = 32'h0;
        b_ra = 5'd0; b_rb = 5'd0; b_dg = 5'd0;
        s_reset = 1'b1; s_clear = 1'b0; s_wen = 1'b0; s_wa = 3'd0; s_wd = 16'h0;
        s_ra = 3'd0; s_rb = 3'd0; s_dg = 3'd0;
        @(posedge clk);
        #1;

        // One-cycle reset pulse: 32 busy cycles, then every entry reads zero
        for (int c = 0; c < 32; c++)
            bs("rst_clear", 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 5'(c), 5'(31 - c), 5'(c),
               32'h0, 32'h0, 32'h0, 1'b0);
        for (int a = 0; a < 32; a++)
            bs("rst_read", 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 5'(a), 5'(31 - a), 5'(a),
               32'h0, 32'h0, 32'h0, 1'b1);

        // r5 write/read on both ports, r0 write discarded
        bs("wr_r5", 1'b0, 1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd5, 5'd5,
           BYP ? 32'hDEADBEEF : 32'h0, BYP ? 32'hDEADBEEF : 32'h0, 32'h0, 1'b1);
        bs("rd_r5_wr_r0", 1'b0, 1'b0, 1'b1, 5'd0, 32'h00001234, 5'd5, 5'd5, 5'd5,
           32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 1'b1);
        bs("rd_r0", 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0,
           32'h0, 32'h0, 32'h0, 1'b1);

        // Same-cycle write to r7 while rt reads it; debug port never forwards
        bs("wr_r7", 1'b0, 1'b0, 1'b1, 5'd7, 32'hA5A5A5A5, 5'd3, 5'd7, 5'd7,
           32'h0, BYP ? 32'hA5A5A5A5 : 32'h0, 32'h0, 1'b1);
        bs("rd_r7", 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 5'd7, 5'd7, 5'd7,
           32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 1'b1);

        // Fill r1..r31 with their index, reading back the previous entry
        for (int i = 1; i < 32; i++)
            bs("fill", 1'b0, 1'b0, 1'b1, 5'(i), 32'(i), 5'(i - 1), 5'd0, 5'(i - 1),
               32'(i - 1), 32'h0, 32'(i - 1), 1'b1);
        bs("fill_rd", 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 5'd31, 5'd3, 5'd30,
           32'd31, 32'd3, 32'd30, 1'b1);

        // Clear request wins over a concurrent write to r3
        bs("clr_req", 1'b0, 1'b1, 1'b1, 5'd3, 32'h55, 5'd4, 5'd31, 5'd3,
           32'd4, 32'd31, 32'd3, 1'b1);
        for (int c = 0; c < 32; c++)
            bs("clr_busy", 1'b0, 1'b0, 1'b1, 5'd9, 32'h99, 5'd9, 5'd9, 5'd9,
               32'h0, 32'h0, 32'h0, 1'b0);
        for (int a = 0; a < 32; a++)
            bs("clr_read", 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 5'(a), 5'(a), 5'(a),
               32'h0, 32'h0, 32'h0, 1'b1);

        // Reset at clear cycle 10 restarts the full 32-cycle clear
        bs("pre_wr", 1'b0, 1'b0, 1'b1, 5'd10, 32'h1010, 5'd0, 5'd0, 5'd0,
           32'h0, 32'h0, 32'h0, 1'b1);
        bs("clr_req2", 1'b0, 1'b1, 1'b0, 5'd0, 32'h0, 5'd10, 5'd10, 5'd10,
           32'h1010, 32'h1010, 32'h1010, 1'b1);
        for (int c = 0; c < 10; c++)
            bs("clr2_busy", 1'b0, 1'b0, 1'b1, 5'd12, 32'hC0C0, 5'd12, 5'd12, 5'd12,
               32'h0, 32'h0, 32'h0, 1'b0);
        bs("rst_mid", 1'b1, 1'b0, 1'b1, 5'd12, 32'hC0C0, 5'd10, 5'd12, 5'd1,
           32'h0, 32'h0, 32'h0, 1'b0);
        for (int c = 0; c < 32; c++)
            bs("rst2_clear", 1'b0, 1'b0, 1'b1, 5'd20, 32'h2020, 5'd20, 5'd12, 5'd10,
               32'h0, 32'h0, 32'h0, 1'b0);
        bs("rst2_rdy", 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 5'd20, 5'd12, 5'd10,
           32'h0, 32'h0, 32'h0, 1'b1);
        bs("rst2_rd", 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 5'd1, 5'd31, 5'd5,
           32'h0, 32'h0, 32'h0, 1'b1);

        // Small instance: 8-cycle clear after reset, 16-bit write/read of r7
        for (int c = 0; c < 8; c++)
            ss("s_clear", 1'b0, 1'b0, 1'b0, 3'd0, 16'h0, 3'(c), 3'(c), 3'(c),
               16'h0, 16'h0, 16'h0, 1'b0);
        ss("s_wr7", 1'b0, 1'b0, 1'b1, 3'd7, 16'hFFFF, 3'd7, 3'd6, 3'd7,
           BYP ? 16'hFFFF : 16'h0, 16'h0, 16'h0, 1'b1);
        ss("s_rd7", 1'b0, 1'b1, 1'b0, 3'd0, 16'h0, 3'd7, 3'd7, 3'd7,
           16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b1);
        for (int c = 0; c < 8; c++)
            ss("s_clr", 1'b0, 1'b0, 1'b0, 3'd0, 16'h0, 3'd7, 3'd7, 3'd7,
               16'h0, 16'h0, 16'h0, 1'b0);
        ss("s_after", 1'b0, 1'b0, 1'b0, 3'd0, 16'h0, 3'd7, 3'd7, 3'd7,
           16'h0, 16'h0, 16'h0, 1'b1);

        @(posedge clk);
        #1;
        total++;
        if ((q_big.size() + q_small.size()) != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending want 0", q_big.size() + q_small.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
